// File: rtl/spi_reg_responder.sv
// rtl/spi_reg_responder.sv - SPI mode-0 slave register bank with local fabric read/write ports.
// Optional host write protection above RO_BASE: define SPI_WRITE_PROTECT_EN.
module spi_reg_responder #(
  parameter int N_REGS  = 16,
  parameter int ADDR_W  = 4,
  parameter int RO_BASE = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_ss_n,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic              loc_wr_en,
  input  logic [ADDR_W-1:0] loc_wr_addr,
  input  logic [7:0]        loc_wr_data,
  input  logic [ADDR_W-1:0] loc_rd_addr,
  output logic [7:0]        loc_rd_data,
  output logic              host_wr_strobe,
  output logic [ADDR_W-1:0] host_wr_addr,
  output logic              xfer_active,
  output logic              frame_err
);

`ifdef SPI_WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t            state, state_next;
  logic [7:0]        regs [N_REGS];
  logic [2:0]        sclk_sr;
  logic [1:0]        mosi_sr;
  logic [2:0]        ss_sr;
  logic [2:0]        bit_cnt;
  logic [6:0]        rx_shift;
  logic [7:0]        tx_shift;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_inc;
  logic              rw;

  logic       sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic       start, stop, rise_act, fall_act, byte_done, host_wr, ro_hit;
  logic [7:0] rx_byte;

  // Stage [1] is the synchronised level; stage [2] is its previous value for edge detection.
  assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
  assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
  assign ss_fall   = ~ss_sr[1] & ss_sr[2];
  assign ss_rise   = ss_sr[1] & ~ss_sr[2];
  assign addr_inc  = addr + 1'b1;
  assign ro_hit    = WP_EN && ({1'b0, addr} >= (ADDR_W+1)'(RO_BASE));

  assign spi_miso    = tx_shift[7];
  assign spi_miso_oe = (state != IDLE);
  assign xfer_active = (state != IDLE);
  assign loc_rd_data = regs[loc_rd_addr];

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state   <= IDLE;
      sclk_sr <= 3'b000;
      mosi_sr <= 2'b00;
      ss_sr   <= 3'b111;
    end else begin
      state   <= state_next;
      sclk_sr <= {sclk_sr[1:0], spi_sclk};
      mosi_sr <= {mosi_sr[0], spi_mosi};
      ss_sr   <= {ss_sr[1:0], spi_ss_n};
    end
  end

  // SCLK edges are only honoured inside a frame and never in the cycle ss_n changes.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    stop       = 1'b0;
    rise_act   = 1'b0;
    fall_act   = 1'b0;
    byte_done  = 1'b0;
    rx_byte    = {rx_shift, mosi_sr[1]};
    if (state == IDLE) begin
      if (ss_fall) begin
        state_next = CMD;
        start      = 1'b1;
      end
    end else if (ss_rise) begin
      state_next = IDLE;
      stop       = 1'b1;
    end else begin
      rise_act  = sclk_rise;
      fall_act  = sclk_fall && (bit_cnt != 3'd0);
      byte_done = sclk_rise && (bit_cnt == 3'd7);
      if (state == CMD && byte_done) state_next = DATA;
    end
    host_wr = byte_done && (state == DATA) && !rw && !ro_hit;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= 8'h00;
      bit_cnt        <= 3'd0;
      rx_shift       <= 7'd0;
      tx_shift       <= 8'h00;
      addr           <= '0;
      rw             <= 1'b0;
      host_wr_strobe <= 1'b0;
      host_wr_addr   <= '0;
      frame_err      <= 1'b0;
    end else begin
      host_wr_strobe <= host_wr;
      frame_err      <= stop && (bit_cnt != 3'd0);
      if (host_wr) host_wr_addr <= addr;
      if (start || stop) begin
        bit_cnt  <= 3'd0;
        rx_shift <= 7'd0;
        tx_shift <= 8'h00;
      end else begin
        if (rise_act) begin
          rx_shift <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
        end
        if (fall_act) tx_shift <= {tx_shift[6:0], 1'b0};
        if (byte_done) begin
          if (state == CMD) begin
            rw   <= rx_byte[7];
            addr <= rx_byte[ADDR_W-1:0];
            if (rx_byte[7]) tx_shift <= regs[rx_byte[ADDR_W-1:0]];
          end else begin
            addr <= addr_inc;
            if (rw) tx_shift <= regs[addr_inc];
          end
        end
      end
      // Host write is placed last so it wins a same-address collision.
      if (loc_wr_en) regs[loc_wr_addr] <= loc_wr_data;
      if (host_wr) regs[addr] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_spi_reg_responder.sv
// tb/tb_spi_reg_responder.sv - Directed table-driven bench for spi_reg_responder.
// Expectations follow SPI_WRITE_PROTECT_EN when the bench is built with it.
module tb_spi_reg_responder;
  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, mosi, ss_n, miso, miso_oe;
  logic       loc_wr_en;
  logic [3:0] loc_wr_addr, loc_rd_addr;
  logic [7:0] loc_wr_data, loc_rd_data;
  logic       host_wr_strobe;
  logic [3:0] host_wr_addr;
  logic       xfer_active, frame_err;

  spi_reg_responder dut (
    .clk_clk(clk), .reset_reset(rst),
    .spi_sclk(sclk), .spi_mosi(mosi), .spi_ss_n(ss_n),
    .spi_miso(miso), .spi_miso_oe(miso_oe),
    .loc_wr_en(loc_wr_en), .loc_wr_addr(loc_wr_addr), .loc_wr_data(loc_wr_data),
    .loc_rd_addr(loc_rd_addr), .loc_rd_data(loc_rd_data),
    .host_wr_strobe(host_wr_strobe), .host_wr_addr(host_wr_addr),
    .xfer_active(xfer_active), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int strobe_cnt = 0;
  int err_cycles = 0;
  logic [3:0] strobe_log [0:255];
  logic [3:0] col_addr;
  logic [7:0] col_data;

  always @(negedge clk) begin
    if (host_wr_strobe) begin
      strobe_log[strobe_cnt[7:0]] = host_wr_addr;
      strobe_cnt++;
    end
    if (frame_err) err_cycles++;
  end

  typedef struct {
    logic        fab_en;
    logic [3:0]  fab_addr;
    logic [7:0]  fab_data;
    int          n;
    logic [23:0] mo;
    logic [23:0] mi;
    int          strobes;
    logic [3:0]  first_wa;
    logic [3:0]  last_wa;
    logic [3:0]  a0;
    logic [7:0]  d0;
    logic [3:0]  a1;
    logic [7:0]  d1;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    loc_rd_addr = a;
    #1;
    d = loc_rd_data;
  endtask

  task automatic xfer_byte(input logic [7:0] mo, input bit collide, output logic [7:0] mi);
    bit seen;
    mi = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      mosi = mo[i];
      repeat (8) @(negedge clk);
      mi[i] = miso;
      sclk = 1'b1;
      if (collide && i == 0) begin
        // Fabric writes every cycle until the host commit is seen, so they overlap the commit cycle.
        loc_wr_addr = col_addr;
        loc_wr_data = col_data;
        loc_wr_en   = 1'b1;
        seen = 1'b0;
        for (int w = 0; w < 12 && !seen; w++) begin
          @(negedge clk);
          seen = host_wr_strobe;
        end
        loc_wr_en = 1'b0;
        check("collide_strobe_seen", {31'd0, seen}, 32'd1);
      end
      repeat (8) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input int n, input logic [23:0] mo, output logic [23:0] mi);
    logic [7:0] b;
    mi = 24'h0;
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      xfer_byte(mo[23-8*k -: 8], 1'b0, b);
      mi[23-8*k -: 8] = b;
    end
    repeat (8) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d, b;
    logic [23:0] mi;
    int s0, e0;

    // fab_en addr data | n mosi miso | strobes first last | a0 d0 a1 d1
    vecs.push_back('{1'b0, 4'h0, 8'h00, 3, 24'h035AC3, 24'h000000, 2, 4'h3, 4'h4, 4'h3, 8'h5A, 4'h4, 8'hC3});
    vecs.push_back('{1'b1, 4'h8, 8'h3C, 0, 24'h000000, 24'h000000, 0, 4'h0, 4'h0, 4'h8, 8'h3C, 4'h7, 8'h00});
    vecs.push_back('{1'b1, 4'h7, 8'h9E, 3, 24'h870000, 24'h009E3C, 0, 4'h0, 4'h0, 4'h7, 8'h9E, 4'h8, 8'h3C});
`ifdef SPI_WRITE_PROTECT_EN
    vecs.push_back('{1'b0, 4'h0, 8'h00, 3, 24'h0F1122, 24'h000000, 1, 4'h0, 4'h0, 4'hF, 8'h00, 4'h0, 8'h22});
    vecs.push_back('{1'b0, 4'h0, 8'h00, 3, 24'h8F0000, 24'h000022, 0, 4'h0, 4'h0, 4'hF, 8'h00, 4'h0, 8'h22});
`else
    vecs.push_back('{1'b0, 4'h0, 8'h00, 3, 24'h0F1122, 24'h000000, 2, 4'hF, 4'h0, 4'hF, 8'h11, 4'h0, 8'h22});
    vecs.push_back('{1'b0, 4'h0, 8'h00, 3, 24'h8F0000, 24'h001122, 0, 4'h0, 4'h0, 4'hF, 8'h11, 4'h0, 8'h22});
`endif
    vecs.push_back('{1'b0, 4'h0, 8'h00, 2, 24'hF40000, 24'h00C300, 0, 4'h0, 4'h0, 4'h4, 8'hC3, 4'h5, 8'h00});
    vecs.push_back('{1'b0, 4'h0, 8'h00, 2, 24'h01A500, 24'h000000, 1, 4'h1, 4'h1, 4'h1, 8'hA5, 4'h2, 8'h00});
`ifdef SPI_WRITE_PROTECT_EN
    vecs.push_back('{1'b0, 4'h0, 8'h00, 2, 24'h087700, 24'h000000, 0, 4'h0, 4'h0, 4'h8, 8'h3C, 4'h9, 8'h00});
`else
    vecs.push_back('{1'b0, 4'h0, 8'h00, 2, 24'h087700, 24'h000000, 1, 4'h8, 4'h8, 4'h8, 8'h77, 4'h9, 8'h00});
`endif

    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
    loc_wr_en = 1'b0; loc_wr_addr = 4'h0; loc_wr_data = 8'h00; loc_rd_addr = 4'h0;
    col_addr = 4'h0; col_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("reset_xfer_active", {31'd0, xfer_active}, 32'd0);
    check("reset_miso", {31'd0, miso}, 32'd0);
    check("reset_host_wr_strobe", {31'd0, host_wr_strobe}, 32'd0);
    for (int a = 0; a < 16; a++) begin
      rd(a[3:0], d);
      check($sformatf("reset_reg%0d", a), {24'd0, d}, 32'd0);
    end
    @(negedge clk);

    for (int v = 0; v < vecs.size(); v++) begin
      if (vecs[v].fab_en) begin
        loc_wr_addr = vecs[v].fab_addr;
        loc_wr_data = vecs[v].fab_data;
        loc_wr_en   = 1'b1;
        @(negedge clk);
        loc_wr_en   = 1'b0;
        @(negedge clk);
      end
      s0 = strobe_cnt;
      if (vecs[v].n > 0) frame(vecs[v].n, vecs[v].mo, mi);
      for (int k = 0; k < vecs[v].n; k++)
        check($sformatf("v%0d_miso_byte%0d", v, k), {24'd0, mi[23-8*k -: 8]}, {24'd0, vecs[v].mi[23-8*k -: 8]});
      check($sformatf("v%0d_strobes", v), strobe_cnt - s0, vecs[v].strobes);
      if (vecs[v].strobes > 0) begin
        check($sformatf("v%0d_first_wr_addr", v), {28'd0, strobe_log[s0[7:0]]}, {28'd0, vecs[v].first_wa});
        check($sformatf("v%0d_host_wr_addr", v), {28'd0, host_wr_addr}, {28'd0, vecs[v].last_wa});
      end
      rd(vecs[v].a0, d);
      check($sformatf("v%0d_reg%0d", v, vecs[v].a0), {24'd0, d}, {24'd0, vecs[v].d0});
      rd(vecs[v].a1, d);
      check($sformatf("v%0d_reg%0d", v, vecs[v].a1), {24'd0, d}, {24'd0, vecs[v].d1});
      @(negedge clk);
    end
    check("clean_frames_no_err", err_cycles, 0);

    // Host and fabric hitting reg2 in the same cycle: host data must survive.
    col_addr = 4'h2; col_data = 8'hAA;
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    check("in_frame_xfer_active", {31'd0, xfer_active}, 32'd1);
    check("in_frame_miso_oe", {31'd0, miso_oe}, 32'd1);
    xfer_byte(8'h02, 1'b0, b);
    xfer_byte(8'h55, 1'b1, b);
    repeat (8) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
    rd(4'h2, d);
    check("collide_same_addr_reg2", {24'd0, d}, 32'h55);

    col_addr = 4'hA; col_data = 8'hBB;
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    xfer_byte(8'h03, 1'b0, b);
    xfer_byte(8'h66, 1'b1, b);
    repeat (8) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
    rd(4'h3, d);
    check("collide_diff_addr_reg3", {24'd0, d}, 32'h66);
    rd(4'hA, d);
    check("collide_diff_addr_reg10", {24'd0, d}, 32'hBB);

    // Abort after 5 data bits targeting reg6.
    s0 = strobe_cnt;
    e0 = err_cycles;
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    xfer_byte(8'h06, 1'b0, b);
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_frame_err_cycles", err_cycles - e0, 1);
    check("abort_no_strobe", strobe_cnt - s0, 0);
    check("abort_xfer_active", {31'd0, xfer_active}, 32'd0);
    check("abort_miso_oe", {31'd0, miso_oe}, 32'd0);
    rd(4'h6, d);
    check("abort_reg6_unchanged", {24'd0, d}, 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
- SPI mode-0 slave register file: the far end of the SoC's spi0 master link (SCLK/MOSI/MISO/SS_n).
- Lets the Nios firmware read and write a bank of 8-bit registers over SPI.
- Fabric logic shares the bank through a local read port and a local write port.
- SPI pins are sampled in the system clock domain; no SCLK-clocked flops.

Parameters:
- N_REGS, 16, number of 8-bit registers (power of two).
- ADDR_W, 4, log2(N_REGS).
- RO_BASE, 8, first host-read-only address; used only with SPI_WRITE_PROTECT_EN.

Ports:
- clk_clk  in  1  system clock; must be >= 8x SCLK.
- reset_reset  in  1  asynchronous active-high reset.
- spi_sclk  in  1  SPI clock from master; idle low.
- spi_mosi  in  1  master-out data.
- spi_ss_n  in  1  active-low slave select.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  MISO output enable; pad is tri-stated when 0.
- loc_wr_en  in  1  fabric write strobe.
- loc_wr_addr  in  ADDR_W  fabric write address.
- loc_wr_data  in  8  fabric write data.
- loc_rd_addr  in  ADDR_W  fabric read address.
- loc_rd_data  out  8  combinational reg[loc_rd_addr].
- host_wr_strobe  out  1  1-cycle pulse when the host commits a register write.
- host_wr_addr  out  ADDR_W  address of the last host write.
- xfer_active  out  1  high while a frame is in progress.
- frame_err  out  1  1-cycle pulse when a frame aborts mid-byte.

Behaviour:
- Reset: all registers 0x00; spi_miso 0; spi_miso_oe 0; host_wr_strobe 0; host_wr_addr 0; xfer_active 0; frame_err 0; state IDLE.
- Synchronisers: sclk, mosi and ss_n each pass through 2 flops, then edge detect. Latency from pin to action is 3 clk.
- States are IDLE, CMD and DATA.
- IDLE -> CMD on ss_n falling edge:
  - bit_cnt=0; tx_shift=0x00; xfer_active=1; spi_miso_oe=1.
- SCLK rising edge: rx_shift <= {rx_shift[6:0], mosi}; bit_cnt++ (mod 8).
- SCLK falling edge with bit_cnt != 0: tx_shift <= {tx_shift[6:0], 0}.
  - Falling edge with bit_cnt == 0 does not shift, so a freshly loaded byte keeps its MSB.
- spi_miso = tx_shift[7] at all times. Bits are MSB-first.
- Byte completes on the 8th rising edge (bit_cnt wraps to 0).
- In CMD, on completion:
  - rw = rx byte bit7 (1 = read); addr = rx byte bits[ADDR_W-1:0]; upper address bits are ignored; -> DATA.
  - On a read, tx_shift <= reg[addr] in the same cycle.
- In DATA, on completion:
  - Write: reg[addr] <= rx byte; host_wr_strobe=1; host_wr_addr=addr; addr <= addr+1.
  - Read: addr <= addr+1; tx_shift <= reg[addr+1].
  - addr wraps mod N_REGS (15 -> 0).
  - On a write frame, MISO shifts 0x00.
- Read data is the register value in the load cycle; later changes do not affect the byte in flight.
- ss_n rising edge in any state -> IDLE:
  - xfer_active=0; spi_miso_oe=0; partial byte discarded.
  - frame_err pulses if bit_cnt != 0.
- Fabric write to reg[loc_wr_addr] occurs every cycle loc_wr_en=1.
- Same-cycle host write and fabric write to the same address: host wins. Different addresses: both commit.
- SCLK edges while ss_n high are ignored.
- An ss_n falling edge in the same synced cycle as an SCLK edge: the frame starts and that SCLK edge is ignored.

Optional Feature:
- Macro SPI_WRITE_PROTECT_EN.
- Defined:
  - Host writes to addr >= RO_BASE are dropped: no register change, no host_wr_strobe. addr still increments.
  - Fabric writes are unaffected. These registers hold fabric status such as keycodes.
- Undefined: all registers are host-writable and RO_BASE is unused.

Test Plan:
- Reset -> loc_rd_data=0x00 for all addresses; spi_miso_oe=0; xfer_active=0.
- Host frame 0x03,0x5A,0xC3 (write, addr 3) -> reg[3]=0x5A, reg[4]=0xC3; two host_wr_strobe pulses with host_wr_addr 3 then 4; MISO shifts 0x00,0x00,0x00.
- Fabric writes reg[7]=0x9E; host frame 0x87,xx,xx -> MISO bytes 0x00,0x9E,reg[8].
- Write-wrap: host 0x0F,0x11,0x22 -> reg[15]=0x11, reg[0]=0x22.
- Abort: ss_n raised after 5 SCLK rising edges of a data byte -> frame_err 1-cycle pulse; target register unchanged; xfer_active=0.
- With SPI_WRITE_PROTECT_EN: host 0x08,0x77 -> reg[8] unchanged, no host_wr_strobe. Same cycle host write and loc_wr to reg[2] -> host data retained.
